// File: rtl/ctrl_pkt_master_pkg.sv
// ctrl_pkt_master_pkg
// Shared definitions for the control-packet initiator: chain word layout
// (field bit positions), word position codes, packet type codes, the FSM
// state encoding and a helper that assembles a head word.
package ctrl_pkt_master_pkg;

    localparam int WORD_W = 134;

    // Field bit positions inside a chain word
    localparam int POS_HI  = 133;
    localparam int POS_LO  = 132;
    localparam int TYPE_HI = 126;
    localparam int TYPE_LO = 124;
    localparam int TAG_HI  = 123;
    localparam int TAG_LO  = 112;
    localparam int SRC_HI  = 111;
    localparam int SRC_LO  = 104;
    localparam int DST_HI  = 103;
    localparam int DST_LO  = 96;
    localparam int ADDR_HI = 71;
    localparam int ADDR_LO = 64;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    // Word position codes
    localparam logic [1:0] POS_HEAD = 2'b01;
    localparam logic [1:0] POS_MID  = 2'b11;
    localparam logic [1:0] POS_TAIL = 2'b10;

    // Packet type codes carried by the head word
    localparam logic [2:0] TYPE_RD   = 3'b001;
    localparam logic [2:0] TYPE_WR   = 3'b010;
    localparam logic [2:0] TYPE_RACK = 3'b011;

    // A tail word carries nothing but its position code
    localparam logic [WORD_W-1:0] TAIL_WORD = {POS_TAIL, {(WORD_W-2){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEAD     = 3'd1,
        TAIL     = 3'd2,
        WAIT_ACK = 3'd3,
        RESP     = 3'd4
    } state_t;

    function automatic logic [WORD_W-1:0] make_head(
        input logic [2:0]  typ,
        input logic [11:0] tag,
        input logic [7:0]  src,
        input logic [7:0]  dst,
        input logic [7:0]  addr,
        input logic [31:0] data
    );
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[POS_HI:POS_LO]   = POS_HEAD;
        w[TYPE_HI:TYPE_LO] = typ;
        w[TAG_HI:TAG_LO]   = tag;
        w[SRC_HI:SRC_LO]   = src;
        w[DST_HI:DST_LO]   = dst;
        w[ADDR_HI:ADDR_LO] = addr;
        w[DATA_HI:DATA_LO] = data;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_pkt_master_if.sv
// ctrl_pkt_master_if
// Bundles the command, chain-output, chain-input and response signals of the
// control-packet initiator.
//   master : view of the initiator (drives cmd_ready, cout_*, rsp_*)
//   slave  : view of the environment (drives cmd_*, cin_*)
interface ctrl_pkt_master_if;
    import ctrl_pkt_master_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [7:0]        cmd_dst_mid;
    logic [7:0]        cmd_addr;
    logic [31:0]       cmd_wdata;

    logic [WORD_W-1:0] cout_data;
    logic              cout_data_wr;
    logic              cin_ready;
    logic [WORD_W-1:0] cin_data;
    logic              cin_data_wr;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_timeout;

    modport master (
        input  cmd_valid, cmd_rw, cmd_dst_mid, cmd_addr, cmd_wdata,
        input  cin_ready, cin_data, cin_data_wr,
        output cmd_ready, cout_data, cout_data_wr,
        output rsp_valid, rsp_rdata, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_dst_mid, cmd_addr, cmd_wdata,
        output cin_ready, cin_data, cin_data_wr,
        input  cmd_ready, cout_data, cout_data_wr,
        input  rsp_valid, rsp_rdata, rsp_timeout
    );

endinterface

// File: rtl/cpm_ack_match.sv
// cpm_ack_match
// Combinational read-ack recogniser. A word matches when it is strobed, is a
// head word of type read-ack, is addressed to this initiator, comes from the
// module we sent the read to, and carries the tag and address we sent.
// Ports:
//   word, word_wr   incoming chain word and its strobe
//   own_mid         this initiator's module ID (expected ack destination)
//   exp_src         module ID the read was sent to (expected ack source)
//   exp_tag         tag of the outstanding read
//   exp_addr        register address of the outstanding read
//   match           1 when the word is the ack for the outstanding read
module cpm_ack_match
    import ctrl_pkt_master_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic              word_wr,
    input  logic [7:0]        own_mid,
    input  logic [7:0]        exp_src,
    input  logic [11:0]       exp_tag,
    input  logic [7:0]        exp_addr,
    output logic              match
);

    assign match = word_wr
                && (word[POS_HI:POS_LO]     == POS_HEAD)
                && (word[TYPE_HI:TYPE_LO]   == TYPE_RACK)
                && (word[DST_HI:DST_LO]     == own_mid)
                && (word[SRC_HI:SRC_LO]     == exp_src)
                && (word[TAG_HI:TAG_LO]     == exp_tag)
                && (word[ADDR_HI:ADDR_LO]   == exp_addr);

    // Bits the comparator deliberately ignores (reserved fields and payload)
    logic unused_word_bits;
    assign unused_word_bits = ^{word[131:127], word[95:72], word[63:0]};

endmodule

// File: rtl/ctrl_pkt_master.sv
// ctrl_pkt_master
// Control-packet initiator. Accepts one read or write command at a time,
// sends it on the chain as a head word followed by a tail word, and for a
// read waits (bounded by TIMEOUT cycles) for the matching read-ack head.
// Each command ends with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (master)        cmd_* command handshake, cout_* / cin_* chain words,
//                       rsp_* completion (rsp_timeout qualifies rsp_valid)
//   tx_cnt              packets sent
//   ack_cnt             read-acks matched
//   to_cnt              read timeouts
module ctrl_pkt_master
    import ctrl_pkt_master_pkg::*;
#(
    parameter logic [7:0]  SRC_MID = 8'd1,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic              clk,
    input  logic              rst_n,
    ctrl_pkt_master_if.master bus,
    output logic [31:0]       tx_cnt,
    output logic [31:0]       ack_cnt,
    output logic [31:0]       to_cnt
);

    localparam logic [15:0] TIMER_LAST = TIMEOUT - 16'd1;

    state_t            state_reg;
    logic              rw_reg;
    logic [7:0]        dst_reg;
    logic [7:0]        addr_reg;
    logic [11:0]       tag_reg;        // tag for the next packet
    logic [11:0]       sent_tag_reg;   // tag of the packet in flight
    logic [15:0]       timer_reg;
    logic [WORD_W-1:0] cout_data_reg;
    logic              cout_pend_reg;  // a head or tail word is waiting to go
    logic              cmd_ready_reg;
    logic              rsp_valid_reg;
    logic              rsp_timeout_reg;
    logic [31:0]       rsp_rdata_reg;
    logic [31:0]       tx_cnt_reg;
    logic [31:0]       ack_cnt_reg;
    logic [31:0]       to_cnt_reg;
    logic              ack_match;

    cpm_ack_match u_ack_match (
        .word     (bus.cin_data),
        .word_wr  (bus.cin_data_wr),
        .own_mid  (SRC_MID),
        .exp_src  (dst_reg),
        .exp_tag  (sent_tag_reg),
        .exp_addr (addr_reg),
        .match    (ack_match)
    );

    // The outgoing word is prepared one step ahead (head at acceptance, tail
    // once the head is taken), so a word is presented in the same cycle the
    // FSM reaches HEAD/TAIL and only the strobe depends on cin_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rw_reg          <= 1'b0;
            dst_reg         <= '0;
            addr_reg        <= '0;
            tag_reg         <= '0;
            sent_tag_reg    <= '0;
            timer_reg       <= '0;
            cout_data_reg   <= '0;
            cout_pend_reg   <= 1'b0;
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rsp_rdata_reg   <= '0;
            tx_cnt_reg      <= '0;
            ack_cnt_reg     <= '0;
            to_cnt_reg      <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_reg) begin
                        rw_reg        <= bus.cmd_rw;
                        dst_reg       <= bus.cmd_dst_mid;
                        addr_reg      <= bus.cmd_addr;
                        sent_tag_reg  <= tag_reg;
                        cout_data_reg <= make_head(bus.cmd_rw ? TYPE_RD : TYPE_WR,
                                                   tag_reg, SRC_MID,
                                                   bus.cmd_dst_mid, bus.cmd_addr,
                                                   bus.cmd_rw ? 32'd0 : bus.cmd_wdata);
                        cout_pend_reg <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= HEAD;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                HEAD: begin
                    if (bus.cin_ready) begin
                        cout_data_reg <= TAIL_WORD;
                        state_reg     <= TAIL;
                    end
                end
                TAIL: begin
                    if (bus.cin_ready) begin
                        cout_data_reg <= '0;
                        cout_pend_reg <= 1'b0;
                        tx_cnt_reg    <= tx_cnt_reg + 32'd1;
                        tag_reg       <= tag_reg + 12'd1;
                        if (rw_reg) begin
                            timer_reg <= '0;
                            state_reg <= WAIT_ACK;
                        end else begin
                            rsp_valid_reg   <= 1'b1;
                            rsp_rdata_reg   <= '0;
                            rsp_timeout_reg <= 1'b0;
                            state_reg       <= RESP;
                        end
                    end
                end
                WAIT_ACK: begin
                    // A match is checked first so it wins over expiry
                    if (ack_match) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= bus.cin_data[DATA_HI:DATA_LO];
                        rsp_timeout_reg <= 1'b0;
                        ack_cnt_reg     <= ack_cnt_reg + 32'd1;
                        state_reg       <= RESP;
                    end else if (timer_reg == TIMER_LAST) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_timeout_reg <= 1'b1;
                        to_cnt_reg      <= to_cnt_reg + 32'd1;
                        state_reg       <= RESP;
                    end else begin
                        timer_reg <= timer_reg + 16'd1;
                    end
                end
                RESP: begin
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    cout_pend_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_reg;
    assign bus.cout_data    = cout_data_reg;
    assign bus.cout_data_wr = cout_pend_reg & bus.cin_ready;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_rdata    = rsp_rdata_reg;
    assign bus.rsp_timeout  = rsp_timeout_reg;
    assign tx_cnt           = tx_cnt_reg;
    assign ack_cnt          = ack_cnt_reg;
    assign to_cnt           = to_cnt_reg;

endmodule

// File: tb/tb_ctrl_pkt_master.sv
// tb_ctrl_pkt_master
// Self-checking bench for ctrl_pkt_master. A transaction-level model (next
// tag, expected counters, expected words and completion cycle) predicts
// every observed value. Directed transactions cover the documented scenarios,
// followed by randomized traffic and a long write burst that wraps the tag.
module tb_ctrl_pkt_master;

    localparam logic [7:0] SRC = 8'd1;
    localparam int         TO  = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] tx_cnt;
    logic [31:0] ack_cnt;
    logic [31:0] to_cnt;

    ctrl_pkt_master_if bus_if ();

    ctrl_pkt_master #(
        .SRC_MID (SRC),
        .TIMEOUT (16'(TO))
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .tx_cnt  (tx_cnt),
        .ack_cnt (ack_cnt),
        .to_cnt  (to_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          txn_no   = 0;
    int          model_tag;
    logic [31:0] exp_tx;
    logic [31:0] exp_ack;
    logic [31:0] exp_to;

    task automatic check_eq(input string name, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [133:0] mk_word(input logic [1:0] pos, input logic [2:0] typ,
                                             input logic [11:0] tag, input logic [7:0] src,
                                             input logic [7:0] dst, input logic [7:0] addr,
                                             input logic [31:0] data);
        logic [133:0] w;
        w            = '0;
        w[133:132]   = pos;
        w[126:124]   = typ;
        w[123:112]   = tag;
        w[111:104]   = src;
        w[103:96]    = dst;
        w[71:64]     = addr;
        w[31:0]      = data;
        return w;
    endfunction

    function automatic logic [133:0] rand_word();
        return {6'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Words that must never be taken as the ack for (tag, dst, addr)
    function automatic logic [133:0] junk_word(input int kind, input logic [11:0] tag,
                                               input logic [7:0] dst, input logic [7:0] addr);
        logic [31:0] d;
        d = $urandom;
        case (kind)
            0: return mk_word(2'b01, 3'b011, tag ^ 12'(1 << $urandom_range(0, 11)), dst, SRC, addr, d);
            1: return mk_word(2'b01, 3'b011, tag, dst, SRC, addr ^ 8'($urandom_range(1, 255)), d);
            2: return mk_word(2'b01, 3'b011, tag, dst ^ 8'($urandom_range(1, 255)), SRC, addr, d);
            3: return mk_word(2'b01, 3'b011, tag, dst, SRC ^ 8'($urandom_range(1, 255)), addr, d);
            4: return mk_word(2'b01, ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b010, tag, dst, SRC, addr, d);
            default: return mk_word(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, 3'b011, tag, dst, SRC, addr, d);
        endcase
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_cmd_ready"},   134'(bus_if.cmd_ready),    134'(0));
        check_eq({pfx, "_cout_data"},   bus_if.cout_data,          134'(0));
        check_eq({pfx, "_cout_wr"},     134'(bus_if.cout_data_wr), 134'(0));
        check_eq({pfx, "_rsp_valid"},   134'(bus_if.rsp_valid),    134'(0));
        check_eq({pfx, "_rsp_rdata"},   134'(bus_if.rsp_rdata),    134'(0));
        check_eq({pfx, "_rsp_timeout"}, 134'(bus_if.rsp_timeout),  134'(0));
        check_eq({pfx, "_tx_cnt"},      134'(tx_cnt),              134'(0));
        check_eq({pfx, "_ack_cnt"},     134'(ack_cnt),             134'(0));
        check_eq({pfx, "_to_cnt"},      134'(to_cnt),              134'(0));
    endtask

    task automatic model_reset();
        model_tag = 0;
        exp_tx    = '0;
        exp_ack   = '0;
        exp_to    = '0;
    endtask

    // Pulse reset from IDLE (or anywhere) and check the held-reset outputs
    task automatic apply_reset(input string pfx);
        @(negedge clk);
        bus_if.cin_data_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(pfx);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq({pfx, "_held_ready"}, 134'(bus_if.cmd_ready), 134'(0));
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq({pfx, "_ready_after"}, 134'(bus_if.cmd_ready), 134'(1));
    endtask

    // One command from acceptance to completion.
    //   ack_mode 0: correct ack at WAIT_ACK cycle ack_at (junk before it)
    //   ack_mode 1: no ack, timeout, then a late ack that must be ignored
    //   ack_mode 2: reset asserted at WAIT_ACK cycle ack_at
    //   junk_kind -1 picks a random non-matching word kind, else fixed kind
    task automatic do_txn(input bit rw, input logic [7:0] dst, input logic [7:0] addr,
                          input logic [31:0] wdata, input int hstall, input int tstall,
                          input int ack_mode, input int ack_at, input logic [31:0] ack_data,
                          input int junk_pct, input int junk_kind, input bit verbose);
        logic [133:0] exp_head;
        logic [133:0] exp_tail;
        logic [133:0] ack_word;
        logic [11:0]  tag;
        int           waited;
        int           done_c;
        int           kind;

        tag      = 12'(model_tag);
        exp_head = mk_word(2'b01, rw ? 3'b001 : 3'b010, tag, SRC, dst, addr, rw ? 32'd0 : wdata);
        exp_tail = '0;
        exp_tail[133:132] = 2'b10;
        ack_word = mk_word(2'b01, 3'b011, tag, dst, SRC, addr, ack_data);
        txn_no++;

        waited = 0;
        while (bus_if.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("cmd_ready_idle", 134'(bus_if.cmd_ready), 134'(1));

        bus_if.cin_data_wr = 1'b0;
        bus_if.cmd_valid   = 1'b1;
        bus_if.cmd_rw      = rw;
        bus_if.cmd_dst_mid = dst;
        bus_if.cmd_addr    = addr;
        bus_if.cmd_wdata   = wdata;
        bus_if.cin_ready   = (hstall == 0);
        @(negedge clk);
        // Scramble the command inputs: the packet must use the accepted values
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_rw      = 1'($urandom);
        bus_if.cmd_dst_mid = 8'($urandom);
        bus_if.cmd_addr    = 8'($urandom);
        bus_if.cmd_wdata   = $urandom;

        for (int s = 0; s < hstall; s++) begin
            bus_if.cin_ready = 1'b0;
            #1;
            check_eq("head_stall_wr", 134'(bus_if.cout_data_wr), 134'(0));
            check_eq("busy_ready", 134'(bus_if.cmd_ready), 134'(0));
            @(negedge clk);
        end
        bus_if.cin_ready = 1'b1;
        #1;
        check_eq("head_wr", 134'(bus_if.cout_data_wr), 134'(1));
        check_eq("head_word", bus_if.cout_data, exp_head);
        @(negedge clk);
        for (int s = 0; s < tstall; s++) begin
            bus_if.cin_ready = 1'b0;
            #1;
            check_eq("tail_stall_wr", 134'(bus_if.cout_data_wr), 134'(0));
            @(negedge clk);
        end
        bus_if.cin_ready = 1'b1;
        #1;
        check_eq("tail_wr", 134'(bus_if.cout_data_wr), 134'(1));
        check_eq("tail_word", bus_if.cout_data, exp_tail);
        model_tag = (model_tag + 1) & 32'hFFF;
        exp_tx    = exp_tx + 32'd1;
        @(negedge clk);

        if (!rw) begin
            #1;
            check_eq("wr_rsp_valid", 134'(bus_if.rsp_valid), 134'(1));
            check_eq("wr_rsp_rdata", 134'(bus_if.rsp_rdata), 134'(0));
            check_eq("wr_rsp_timeout", 134'(bus_if.rsp_timeout), 134'(0));
            check_eq("wr_tx_cnt", 134'(tx_cnt), 134'(exp_tx));
            check_eq("wr_resp_cout_wr", 134'(bus_if.cout_data_wr), 134'(0));
            @(negedge clk);
            check_eq("wr_rsp_pulse_end", 134'(bus_if.rsp_valid), 134'(0));
            check_eq("wr_ready_again", 134'(bus_if.cmd_ready), 134'(1));
            if (verbose)
                $display("txn %0d WRITE dst=%02h addr=%02h wdata=%08h tag=%03h hstall=%0d tstall=%0d",
                         txn_no, dst, addr, wdata, tag, hstall, tstall);
            return;
        end

        done_c = (ack_mode == 0) ? ack_at + 1 : TO;
        for (int c = 0; c <= done_c + 1; c++) begin
            bus_if.cin_data_wr = 1'b0;
            bus_if.cin_data    = rand_word();
            if (ack_mode == 2 && c == ack_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("rst_wait");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                // The old ack arrives after reset: nothing may complete
                for (int k = 0; k < 6; k++) begin
                    bus_if.cin_data_wr = 1'b1;
                    bus_if.cin_data    = ack_word;
                    @(negedge clk);
                    check_eq("rst_no_rsp", 134'(bus_if.rsp_valid), 134'(0));
                    check_eq("rst_no_ack_cnt", 134'(ack_cnt), 134'(0));
                end
                bus_if.cin_data_wr = 1'b0;
                check_eq("rst_cout_wr", 134'(bus_if.cout_data_wr), 134'(0));
                if (verbose)
                    $display("txn %0d READ dst=%02h addr=%02h tag=%03h reset at wait cycle %0d",
                             txn_no, dst, addr, tag, ack_at);
                return;
            end
            if (ack_mode == 0 && c == ack_at) begin
                bus_if.cin_data_wr = 1'b1;
                bus_if.cin_data    = ack_word;
            end else if (ack_mode == 1 && c >= done_c) begin
                bus_if.cin_data_wr = 1'b1;
                bus_if.cin_data    = ack_word;
            end else if (c < done_c && int'($urandom_range(0, 99)) < junk_pct) begin
                kind = (junk_kind < 0) ? int'($urandom_range(0, 6)) : junk_kind;
                if (kind == 6) begin
                    bus_if.cin_data_wr = 1'b0;
                    bus_if.cin_data    = ack_word;
                end else begin
                    bus_if.cin_data_wr = 1'b1;
                    bus_if.cin_data    = junk_word(kind, tag, dst, addr);
                end
            end
            #1;
            if (c == done_c) begin
                if (ack_mode == 0) exp_ack = exp_ack + 32'd1;
                else               exp_to  = exp_to + 32'd1;
                check_eq("rd_rsp_valid", 134'(bus_if.rsp_valid), 134'(1));
                check_eq("rd_rsp_timeout", 134'(bus_if.rsp_timeout), 134'(ack_mode == 1));
                check_eq("rd_rsp_rdata", 134'(bus_if.rsp_rdata), 134'((ack_mode == 0) ? ack_data : 32'd0));
                check_eq("rd_ack_cnt", 134'(ack_cnt), 134'(exp_ack));
                check_eq("rd_to_cnt", 134'(to_cnt), 134'(exp_to));
                check_eq("rd_tx_cnt", 134'(tx_cnt), 134'(exp_tx));
            end else if (c == done_c + 1) begin
                check_eq("rd_rsp_pulse_end", 134'(bus_if.rsp_valid), 134'(0));
                check_eq("rd_ready_again", 134'(bus_if.cmd_ready), 134'(1));
                check_eq("rd_late_ack_cnt", 134'(ack_cnt), 134'(exp_ack));
            end else begin
                check_eq("rd_wait_no_rsp", 134'(bus_if.rsp_valid), 134'(0));
                check_eq("rd_wait_cout_wr", 134'(bus_if.cout_data_wr), 134'(0));
            end
            @(negedge clk);
        end
        bus_if.cin_data_wr = 1'b0;
        if (verbose)
            $display("txn %0d READ dst=%02h addr=%02h tag=%03h hstall=%0d tstall=%0d %s at=%0d rdata=%08h",
                     txn_no, dst, addr, tag, hstall, tstall,
                     (ack_mode == 0) ? "ack" : "timeout", done_c,
                     (ack_mode == 0) ? ack_data : 32'd0);
    endtask

    initial begin
        int n_burst;
        bit rw;
        int mode;

        rst_n              = 1'b1;
        bus_if.cmd_valid   = 1'b0;
        bus_if.cmd_rw      = 1'b0;
        bus_if.cmd_dst_mid = '0;
        bus_if.cmd_addr    = '0;
        bus_if.cmd_wdata   = '0;
        bus_if.cin_ready   = 1'b1;
        bus_if.cin_data    = '0;
        bus_if.cin_data_wr = 1'b0;
        model_reset();

        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("por_ready_after", 134'(bus_if.cmd_ready), 134'(1));

        // Documented write, then a reset so the documented read uses tag 0
        do_txn(1'b0, 8'h05, 8'h07, 32'h12345678, 0, 0, 0, 0, 32'd0, 0, -1, 1'b1);
        apply_reset("rst_idle");
        do_txn(1'b1, 8'h05, 8'h03, 32'd0, 0, 0, 0, 9, 32'h000000AA, 0, -1, 1'b1);
        // Timeout followed by a late ack
        do_txn(1'b1, 8'h05, 8'h10, 32'd0, 0, 0, 1, 0, 32'h0, 0, -1, 1'b1);
        // Five-cycle stall in HEAD
        do_txn(1'b0, 8'h22, 8'h44, 32'hCAFEF00D, 5, 0, 0, 0, 32'd0, 0, -1, 1'b1);
        // Wrong-tag acks before the correct one
        do_txn(1'b1, 8'h09, 8'h31, 32'd0, 0, 0, 0, 6, 32'h5A5A1234, 100, 0, 1'b1);
        // Match in the expiry cycle
        do_txn(1'b1, 8'h0C, 8'h7E, 32'd0, 0, 1, 0, TO - 1, 32'hDEADBEEF, 50, -1, 1'b1);
        // Reset in WAIT_ACK, then a read that must carry tag 0 again
        do_txn(1'b1, 8'h05, 8'h03, 32'd0, 0, 0, 2, 4, 32'h0, 0, -1, 1'b1);
        do_txn(1'b1, 8'h05, 8'h03, 32'd0, 0, 0, 0, 2, 32'h00000077, 0, -1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_txn(rw, 8'($urandom), 8'($urandom), $urandom,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   mode, int'($urandom_range(0, TO - 1)), $urandom, 40, -1, 1'b1);
        end

        // Run the tag through 0xFFF -> 0, then confirm a read with the wrapped tag
        n_burst = 4096 - model_tag;
        for (int i = 0; i < n_burst; i++)
            do_txn(1'b0, 8'($urandom), 8'($urandom), $urandom, 0, 0, 0, 0, 32'd0, 0, -1, 1'b0);
        $display("txn burst of %0d writes, next tag %03h", n_burst, model_tag);
        do_txn(1'b1, 8'h3C, 8'h5D, 32'd0, 0, 0, 0, 3, 32'h0BADCAFE, 30, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pkt_master.md
CTRL_PKT_MASTER -- requirements
Module: ctrl_pkt_master

Interface
REQ-001 Parameters SHALL be: SRC_MID, default 8'd1, the module ID of this initiator; TIMEOUT, default 16'd1024, the read-ack wait limit in cycles.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_rw  in  1  0 = write, 1 = read.
REQ-007 cmd_dst_mid  in  8  target module ID.
REQ-008 cmd_addr  in  8  target register address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cout_data  out  134  control packet word sent to the chain.
REQ-011 cout_data_wr  out  1  cout_data valid strobe.
REQ-012 cin_ready  in  1  downstream can accept a word.
REQ-013 cin_data  in  134  returning chain word.
REQ-014 cin_data_wr  in  1  cin_data valid strobe.
REQ-015 rsp_valid  out  1  one-cycle completion pulse.
REQ-016 rsp_rdata  out  32  read data; 0 on write completion or timeout.
REQ-017 rsp_timeout  out  1  qualifies rsp_valid; 1 = read timed out.
REQ-018 tx_cnt, ack_cnt, to_cnt  out  32 each  packets sent, acks matched, timeouts.

Function
REQ-019 Word format SHALL be: [133:132] 01 = head, 11 = middle, 10 = tail; head [126:124] 001 = read, 010 = write, 011 = read-ack; [123:112] = tag; [111:104] = source MID; [103:96] = destination MID; [71:64] = address; [31:0] = data.
REQ-020 The FSM SHALL have the states IDLE, HEAD, TAIL, WAIT_ACK and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance, the block SHALL latch the command fields and move to HEAD.
REQ-022 In HEAD, when cin_ready = 1, it SHALL emit the head word in a single cycle: [133:132] = 01, type from cmd_rw, the current tag, src = SRC_MID, dst = cmd_dst_mid, addr, and data = wdata (0 for a read), with all other bits 0; it SHALL then go to TAIL.
REQ-023 In TAIL, when cin_ready = 1, it SHALL emit a tail word: [133:132] = 10, all other bits 0.
REQ-024 After emitting the tail, the block SHALL increment tx_cnt and the tag (12-bit, 0xFFF wraps to 0), then: a write goes to RESP; a read clears the timer and goes to WAIT_ACK.
REQ-025 When cin_ready = 0 in HEAD or TAIL, the block SHALL hold its state with cout_data_wr = 0; there is no timeout while stalled.
REQ-026 In WAIT_ACK, a word SHALL match when cin_data_wr is set and the word is a head of type 011 whose dst = SRC_MID, src = latched dst_mid, tag = the tag sent, and addr = the latched addr.
REQ-027 On a match, the block SHALL capture [31:0] into rsp_rdata, increment ack_cnt, and go to RESP.
REQ-028 Non-matching words (including the rest of the ack packet and any stale acks) SHALL be ignored in every state.
REQ-029 In WAIT_ACK, the timer SHALL increment every cycle; when it reaches TIMEOUT-1 without a match, the block SHALL set rsp_timeout = 1, rsp_rdata = 0, increment to_cnt, and go to RESP.
REQ-030 If a match and timeout expiry occur in the same cycle, the match SHALL win.
REQ-031 RESP SHALL last one cycle, driving rsp_valid = 1, and then return to IDLE.
REQ-032 Latency (with cin_ready held at 1) SHALL be: write accept -> head +1 cycle, tail +2, rsp_valid +3; read: rsp_valid arrives 1 cycle after the matching head is sampled.
REQ-033 A new command SHALL be accepted no earlier than the cycle after RESP.
REQ-034 All counters SHALL wrap at 2^32.

Reset
REQ-035 Asserting rst_n low SHALL immediately force IDLE, including mid-packet or mid-wait.
REQ-036 During reset, outputs SHALL be: cout_data = 0, cout_data_wr = 0, rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0; cmd_ready = 0 while asserted, then 1 in IDLE after release.
REQ-037 Reset SHALL clear the tag, timer and all counters to 0.
REQ-038 A packet interrupted by reset SHALL NOT be resumed.

Structure
REQ-039 A shared package SHALL hold: the header field bit positions, the type codes 001/010/011, the head/middle/tail codes, and the FSM state encoding.
REQ-040 One sub-module, cpm_ack_match, SHALL hold the combinational ack-match comparator and be used by the FSM.
REQ-041 The design SHALL contain no FIFO and no RAM.

Verification
REQ-042 Write: SRC_MID = 1, dst = 5, addr = 0x07, wdata = 0x12345678, cin_ready = 1 -> head [126:124] = 010, [111:104] = 01, [103:96] = 05, [71:64] = 07, [31:0] = 12345678; tail next cycle; rsp_valid 1 cycle later with rsp_rdata = 0 and tx_cnt = 1.
REQ-043 Read: dst = 5, addr = 0x03, ack head returned 10 cycles after the tail with type 011, src = 05, dst = 01, tag = 0, data = 0x000000AA -> rsp_valid with rsp_rdata = 0xAA and ack_cnt = 1.
REQ-044 Read with no ack, TIMEOUT = 16 -> rsp_valid with rsp_timeout = 1 exactly 16 cycles after entering WAIT_ACK; to_cnt = 1; a late ack is then ignored.
REQ-045 cin_ready low for 5 cycles during HEAD -> no cout_data_wr for 5 cycles, then head and tail in consecutive cycles; fields unchanged.
REQ-046 Wrong-tag ack followed by correct ack, and also a match arriving in the timeout-expiry cycle -> only the correct ack completes, with rsp_timeout = 0; rst_n pulsed in WAIT_ACK -> IDLE, tag = 0, no rsp_valid.
